// File: rtl/vga_draw_pkg.sv
// Shared constants and types for the VGA drawing path: screen size, palette,
// draw-engine states and client slot numbers.
package vga_draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] CYAN  = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FIN
  } draw_state_e;

  localparam int unsigned CLI_CLEAR  = 0;
  localparam int unsigned CLI_BORDER = 1;
  localparam int unsigned CLI_OBST   = 2;
  localparam int unsigned CLI_BIRD   = 3;

endpackage

// File: rtl/plot_rr_picker.sv
// Combinational round-robin picker: searches upward from ptr_i+1 (with wrap)
// and returns the first asserted request as one-hot and as an index.
module plot_rr_picker
  import vga_draw_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the candidates in priority order; the first hit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        onehot_o[cand]  = 1'b1;
        idx_o           = cand;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter pixel port among several rectangle-drawing clients.
// A granted rectangle is rasterised one pixel per clock, clipped to the screen.
module vga_plot_arbiter
  import vga_draw_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = vga_draw_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = vga_draw_pkg::SCREEN_H
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*X_W-1:0]       req_w,
  input  logic [NUM_REQ*Y_W-1:0]       req_h,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Screen limits at the widened sum width so the compare sees the carry bit.
  localparam logic [X_W:0] ScrW = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] ScrH = SCREEN_H[Y_W:0];

  draw_state_e state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     own_q, own_d;
  logic [X_W-1:0]      x_q, x_d, w_q, w_d, cx_q, cx_d;
  logic [Y_W-1:0]      y_q, y_d, h_q, h_d, cy_q, cy_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic                busy_q, busy_d, plot_q, plot_d;
  logic [X_W-1:0]      vx_q, vx_d;
  logic [Y_W-1:0]      vy_q, vy_d;
  logic [COLOUR_W-1:0] vc_q, vc_d;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [IdxW-1:0]     win_idx;
  logic [X_W-1:0]      sel_x, sel_w;
  logic [Y_W-1:0]      sel_y, sel_h;
  logic [COLOUR_W-1:0] sel_col;
  logic [X_W:0]        xsum;
  logic [Y_W:0]        ysum;

  plot_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx)
  );

  assign sel_x   = req_x[win_idx*X_W +: X_W];
  assign sel_y   = req_y[win_idx*Y_W +: Y_W];
  assign sel_w   = req_w[win_idx*X_W +: X_W];
  assign sel_h   = req_h[win_idx*Y_W +: Y_W];
  assign sel_col = req_colour[win_idx*COLOUR_W +: COLOUR_W];

  assign xsum = {1'b0, x_q} + {1'b0, cx_q};
  assign ysum = {1'b0, y_q} + {1'b0, cy_q};

  // Next-state logic: arbitrate in IDLE, raster in SCAN, retire in FIN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    grant_d = '0;
    done_d  = '0;
    busy_d  = busy_q;
    plot_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req != '0) begin
          own_d   = win_idx;
          x_d     = sel_x;
          y_d     = sel_y;
          w_d     = sel_w;
          h_d     = sel_h;
          col_d   = sel_col;
          cx_d    = '0;
          cy_d    = '0;
          grant_d = win_onehot;
          busy_d  = 1'b1;
          state_d = (sel_w == '0 || sel_h == '0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        // Off-screen pixels still take their cycle, just without the write strobe.
        vx_d   = xsum[X_W-1:0];
        vy_d   = ysum[Y_W-1:0];
        vc_d   = col_q;
        plot_d = (xsum < ScrW) && (ysum < ScrH);
        if (cx_q == w_q - X_W'(1)) begin
          cx_d = '0;
          cy_d = cy_q + Y_W'(1);
          if (cy_q == h_q - Y_W'(1)) begin
            state_d = FIN;
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      FIN: begin
        done_d  = NUM_REQ'(1) << own_q;
        ptr_d   = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      own_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      plot_q  <= plot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed scenarios plus randomised request sets,
// each rectangle's pixel stream and handshake predicted from plain arithmetic.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [31:0] req_w;
  logic [27:0] req_h;
  logic [11:0] req_colour;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int total = 0;
  int bad   = 0;
  int ptr_m;
  int np;
  int rx[4], ry[4], rw[4], rh[4], rc[4];

  vga_plot_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester strictly after ptr, wrapping around.
  function automatic int pick(input logic [3:0] p, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (p[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_cmd(input int i, input int x, input int y, input int w, input int h,
                         input int c);
    rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = c;
    req_x[i*8 +: 8]      = x[7:0];
    req_y[i*7 +: 7]      = y[6:0];
    req_w[i*8 +: 8]      = w[7:0];
    req_h[i*7 +: 7]      = h[6:0];
    req_colour[i*3 +: 3] = c[2:0];
  endtask

  // Waits (bounded) for the grant, then follows the predicted raster and done.
  task automatic expect_cmd(input int cli, input int max_wait, input bit drop, output int nplot);
    int n;
    int x, y, w, h, col;
    x = rx[cli]; y = ry[cli]; w = rw[cli]; h = rh[cli]; col = rc[cli];
    nplot = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == 4'b0 && n < max_wait);
    chk("grant", 32'(grant), 1 << cli);
    chk("busy_at_grant", 32'(busy), 1);
    chk("plot_at_grant", 32'(vga_plot), 0);
    if (drop) req[cli] = 1'b0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        tick();
        chk("plot", 32'(vga_plot), ((x + c) < 160 && (y + r) < 120) ? 1 : 0);
        chk("pix_x", 32'(vga_x), (x + c) % 256);
        chk("pix_y", 32'(vga_y), (y + r) % 128);
        chk("colour", 32'(vga_colour), col);
        chk("busy_scan", 32'(busy), 1);
        chk("done_early", 32'(done), 0);
        nplot += int'(vga_plot);
      end
    end
    tick();
    chk("done", 32'(done), 1 << cli);
    chk("plot_fin", 32'(vga_plot), 0);
    chk("busy_done", 32'(busy), 1);
    chk("grant_fin", 32'(grant), 0);
    ptr_m = cli;
  endtask

  initial begin
    int win;
    logic [3:0] pend;
    reset = 1'b1;
    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    ptr_m = 3;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(vga_x), 0);
    chk("rst_y", 32'(vga_y), 0);
    chk("rst_colour", 32'(vga_colour), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    reset = 1'b0;

    // Single client near the right edge.
    set_cmd(2, 156, 40, 4, 4, 3);
    req = 4'b0100;
    expect_cmd(2, 5, 1'b1, np);
    chk("t1_nplot", np, 16);
    tick();
    chk("t1_busy_drop", 32'(busy), 0);

    // Two held 1x1 requesters alternate back-to-back.
    set_cmd(0, 10, 10, 1, 1, 2);
    set_cmd(1, 20, 20, 1, 1, 3);
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      win = pick(req, ptr_m);
      chk("alt_order", win, k % 2);
      expect_cmd(win, (k == 0) ? 5 : 1, 1'b0, np);
    end
    req = '0;
    tick();
    chk("alt_idle_grant", 32'(grant), 0);
    chk("alt_idle_busy", 32'(busy), 0);

    // Pointer wrap between client 3 and client 0.
    set_cmd(3, 30, 30, 1, 1, 1);
    req = 4'b1001;
    win = pick(req, ptr_m);
    chk("wrap_first", win, 3);
    expect_cmd(win, 5, 1'b1, np);
    win = pick(req, ptr_m);
    chk("wrap_second", win, 0);
    expect_cmd(win, 1, 1'b1, np);

    // Bottom-right corner clip.
    set_cmd(1, 158, 118, 4, 4, 7);
    req = 4'b0010;
    expect_cmd(1, 5, 1'b1, np);
    chk("clip_nplot", np, 4);

    // Zero-width command.
    set_cmd(3, 5, 5, 0, 5, 2);
    req = 4'b1000;
    expect_cmd(3, 5, 1'b1, np);
    chk("zero_nplot", np, 0);
    tick();
    chk("zero_busy_drop", 32'(busy), 0);

    // Full screen clear.
    set_cmd(0, 0, 0, 160, 120, 0);
    req = 4'b0001;
    expect_cmd(0, 5, 1'b1, np);
    chk("clear_nplot", np, 19200);

    // Randomised request sets, every rectangle small but anywhere in coordinate space.
    for (int it = 0; it < 8; it++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        set_cmd(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 7)));
      end
      req = pend;
      while (pend != 4'b0) begin
        win = pick(pend, ptr_m);
        expect_cmd(win, 5, 1'b1, np);
        pend[win] = 1'b0;
      end
    end

    // Reset during the seventh pixel of a 4x4 command.
    tick();
    set_cmd(1, 50, 60, 4, 4, 5);
    req = 4'b0010;
    np = 0;
    while (grant == 4'b0 && np < 5) begin
      tick();
      np++;
    end
    chk("rst_mid_grant", 32'(grant), 2);
    req = '0;
    repeat (7) tick();
    chk("rst_mid_pix7_x", 32'(vga_x), 52);
    chk("rst_mid_pix7_y", 32'(vga_y), 61);
    chk("rst_mid_pix7_plot", 32'(vga_plot), 1);
    reset = 1'b1;
    tick();
    chk("rst_mid_plot", 32'(vga_plot), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_x", 32'(vga_x), 0);
    reset = 1'b0;
    ptr_m = 3;
    set_cmd(0, 1, 1, 1, 1, 2);
    set_cmd(2, 2, 2, 1, 1, 3);
    set_cmd(3, 3, 3, 1, 1, 4);
    pend = 4'b1101;
    req = pend;
    win = pick(pend, ptr_m);
    chk("post_rst_winner", win, 0);
    while (pend != 4'b0) begin
      win = pick(pend, ptr_m);
      expect_cmd(win, 5, 1'b1, np);
      pend[win] = 1'b0;
    end
    tick();
    chk("final_done", 32'(done), 0);
    chk("final_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
